// File: rtl/pipeline_ctrl.sv
// Pipeline hazard and stall controller for a five-stage pipeline.
// Generates stage-register enables and bubble flushes for load-use
// hazards, taken branches, data-memory wait states and syscall halts.
// It also tracks memory wait time, raises a sticky timeout flag and
// keeps a saturating count of stall cycles.
module pipeline_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memtoReg1_i,
  input  logic [4:0]       writeReg1_i,
  input  logic [4:0]       rs_i,
  input  logic [4:0]       rt_i,
  input  logic             branchTaken_i,
  input  logic             memReq_i,
  input  logic             memAck_i,
  input  logic             syscallFlag3_i,
  input  logic             resume_i,
  output logic             pcEn_o,
  output logic             ifidEn_o,
  output logic             idexEn_o,
  output logic             exmemEn_o,
  output logic             memwbEn_o,
  output logic             ifidFlush_o,
  output logic             idexFlush_o,
  output logic             memwbFlush_o,
  output logic [1:0]       state_o,
  output logic             halted_o,
  output logic             memTimeout_o,
  output logic [7:0]       waitCnt_o,
  output logic [CNT_W-1:0] stallCnt_o
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALT    = 2'd2
  } state_t;

  state_t           state, nextState;
  logic [7:0]       waitCnt, nextWaitCnt;
  logic             memTimeout, setTimeout;
  logic [CNT_W-1:0] stallCnt;
  logic             loadUse;
  logic             memStall;

  // A load whose destination feeds the next instruction; r0 is never a real dependency.
  assign loadUse = memtoReg1_i && (writeReg1_i != 5'd0) &&
                   ((writeReg1_i == rs_i) || (writeReg1_i == rt_i));

  // Memory not ready: a fresh unacknowledged request in RUN, or still no ack in MEMWAIT.
  assign memStall = ((state == RUN) && memReq_i && !memAck_i) ||
                    ((state == MEMWAIT) && !memAck_i);

  // State register with wait counter, sticky timeout and saturating stall counter.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values, whatever the statement order.
    if (rst) begin
      state      <= RUN;
      waitCnt    <= 8'd0;
      memTimeout <= 1'b0;
      stallCnt   <= '0;
    end else begin
      state   <= nextState;
      waitCnt <= nextWaitCnt;
      if (setTimeout) memTimeout <= 1'b1;
      if ((state != HALT) && !pcEn_o && (stallCnt != '1))
        stallCnt <= stallCnt + CNT_W'(1);
    end
  end

  // Next-state and next wait count; an ack always wins over the timeout.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (which would infer a latch).
    nextState   = state;
    nextWaitCnt = waitCnt;
    setTimeout  = 1'b0;
    case (state)
      RUN: begin
        if (syscallFlag3_i) begin
          nextState = HALT;
        end else if (memReq_i && !memAck_i) begin
          nextState   = MEMWAIT;
          nextWaitCnt = 8'd1;
        end
      end
      MEMWAIT: begin
        if (syscallFlag3_i) begin
          nextState   = HALT;
          nextWaitCnt = 8'd0;
        end else if (memAck_i) begin
          nextState   = RUN;
          nextWaitCnt = 8'd0;
        end else if (waitCnt == 8'(TIMEOUT)) begin
          nextState   = HALT;
          nextWaitCnt = 8'd0;
          setTimeout  = 1'b1;
        end else begin
          nextWaitCnt = waitCnt + 8'd1;
        end
      end
      HALT: begin
        if (resume_i && !memTimeout) nextState = RUN;
      end
      default: begin
        nextState   = RUN;
        nextWaitCnt = 8'd0;
      end
    endcase
  end

  // Enables and flushes, combinational from state and inputs in priority order.
  always_comb begin
    pcEn_o       = 1'b1;
    ifidEn_o     = 1'b1;
    idexEn_o     = 1'b1;
    exmemEn_o    = 1'b1;
    memwbEn_o    = 1'b1;
    ifidFlush_o  = 1'b0;
    idexFlush_o  = 1'b0;
    memwbFlush_o = 1'b0;
    if (rst) begin
      {pcEn_o, ifidEn_o, idexEn_o, exmemEn_o, memwbEn_o} = 5'b00000;
      {ifidFlush_o, idexFlush_o, memwbFlush_o}           = 3'b111;
    end else if (state == HALT) begin
      {pcEn_o, ifidEn_o, idexEn_o, exmemEn_o, memwbEn_o} = 5'b00000;
    end else if (syscallFlag3_i) begin
      {pcEn_o, ifidEn_o, idexEn_o, exmemEn_o, memwbEn_o} = 5'b00000;
      memwbFlush_o = 1'b1;
    end else if (memStall) begin
      // Freeze everything upstream of MEM and push a bubble into MEM/WB.
      {pcEn_o, ifidEn_o, idexEn_o, exmemEn_o} = 4'b0000;
      memwbFlush_o = 1'b1;
    end else if (branchTaken_i) begin
      // The hazard, if any, belongs to a squashed instruction and is ignored.
      ifidFlush_o = 1'b1;
      idexFlush_o = 1'b1;
    end else if (loadUse) begin
      pcEn_o      = 1'b0;
      ifidEn_o    = 1'b0;
      idexFlush_o = 1'b1;
    end
  end

  assign state_o      = state;
  assign halted_o     = (state == HALT);
  assign memTimeout_o = memTimeout;
  assign waitCnt_o    = waitCnt;
  assign stallCnt_o   = stallCnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: one cycle per record, expected values
// queued as each cycle is driven and popped for comparison mid-cycle.
// A second instance with a 3-bit stall counter shares the stimulus to
// exercise counter saturation.
module tb_pipeline_ctrl;

  typedef struct {
    logic       rst, memtoReg;
    logic [4:0] writeReg, rs, rt;
    logic       branch, memReq, memAck, syscall, resume;
    logic [4:0] en;       // {pc, ifid, idex, exmem, memwb}
    logic [2:0] fl;       // {ifid, idex, memwb}
    logic [1:0] st;
    logic [7:0] wc;
    logic [15:0] sc;
    logic       ht, to;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic memtoReg1 = 1'b0, branchTaken = 1'b0, memReq = 1'b0, memAck = 1'b0;
  logic syscall = 1'b0, resume = 1'b0;
  logic [4:0] writeReg1 = '0, rs = '0, rt = '0;

  logic pcEn, ifidEn, idexEn, exmemEn, memwbEn, ifidFlush, idexFlush, memwbFlush;
  logic [1:0] state;
  logic halted, memTimeout;
  logic [7:0] waitCnt;
  logic [15:0] stallCnt;

  logic pcEn2, ifidEn2, idexEn2, exmemEn2, memwbEn2, ifidFlush2, idexFlush2, memwbFlush2;
  logic [1:0] state2;
  logic halted2, memTimeout2;
  logic [7:0] waitCnt2;
  logic [2:0] stallCnt2;

  int errors = 0;
  int checks = 0;
  vec_t expQ[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  pipeline_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .memtoReg1_i(memtoReg1), .writeReg1_i(writeReg1),
    .rs_i(rs), .rt_i(rt), .branchTaken_i(branchTaken), .memReq_i(memReq),
    .memAck_i(memAck), .syscallFlag3_i(syscall), .resume_i(resume),
    .pcEn_o(pcEn), .ifidEn_o(ifidEn), .idexEn_o(idexEn), .exmemEn_o(exmemEn),
    .memwbEn_o(memwbEn), .ifidFlush_o(ifidFlush), .idexFlush_o(idexFlush),
    .memwbFlush_o(memwbFlush), .state_o(state), .halted_o(halted),
    .memTimeout_o(memTimeout), .waitCnt_o(waitCnt), .stallCnt_o(stallCnt)
  );

  pipeline_ctrl #(.TIMEOUT(4), .CNT_W(3)) dutSat (
    .clk(clk), .rst(rst), .memtoReg1_i(memtoReg1), .writeReg1_i(writeReg1),
    .rs_i(rs), .rt_i(rt), .branchTaken_i(branchTaken), .memReq_i(memReq),
    .memAck_i(memAck), .syscallFlag3_i(syscall), .resume_i(resume),
    .pcEn_o(pcEn2), .ifidEn_o(ifidEn2), .idexEn_o(idexEn2), .exmemEn_o(exmemEn2),
    .memwbEn_o(memwbEn2), .ifidFlush_o(ifidFlush2), .idexFlush_o(idexFlush2),
    .memwbFlush_o(memwbFlush2), .state_o(state2), .halted_o(halted2),
    .memTimeout_o(memTimeout2), .waitCnt_o(waitCnt2), .stallCnt_o(stallCnt2)
  );

  function automatic vec_t v(input logic r, mr, input logic [4:0] wr, s, t,
                             input logic br, mq, ma, sy, rsm,
                             input logic [4:0] en, input logic [2:0] fl,
                             input logic [1:0] st, input logic [7:0] wc,
                             input logic [15:0] sc, input logic ht, to);
    vec_t x;
    x.rst = r; x.memtoReg = mr; x.writeReg = wr; x.rs = s; x.rt = t;
    x.branch = br; x.memReq = mq; x.memAck = ma; x.syscall = sy; x.resume = rsm;
    x.en = en; x.fl = fl; x.st = st; x.wc = wc; x.sc = sc; x.ht = ht; x.to = to;
    return x;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle, queue its expectation, compare on the falling edge.
  task automatic applyCycle(input vec_t x, input int idx);
    vec_t e;
    rst = x.rst; memtoReg1 = x.memtoReg; writeReg1 = x.writeReg; rs = x.rs; rt = x.rt;
    branchTaken = x.branch; memReq = x.memReq; memAck = x.memAck;
    syscall = x.syscall; resume = x.resume;
    expQ.push_back(x);
    @(negedge clk);
    if (expQ.size() == 0) begin
      errors++;
      $display("FAIL scoreboard empty (cycle %0d)", idx);
    end else begin
      e = expQ.pop_front();
      check("enables", idx, 32'({pcEn, ifidEn, idexEn, exmemEn, memwbEn}), 32'(e.en));
      check("flushes", idx, 32'({ifidFlush, idexFlush, memwbFlush}), 32'(e.fl));
      check("state", idx, 32'(state), 32'(e.st));
      check("waitCnt", idx, 32'(waitCnt), 32'(e.wc));
      check("stallCnt", idx, 32'(stallCnt), 32'(e.sc));
      check("halted", idx, 32'(halted), 32'(e.ht));
      check("memTimeout", idx, 32'(memTimeout), 32'(e.to));
      check("stallCntSat", idx, 32'(stallCnt2), (e.sc > 16'd7) ? 32'd7 : 32'(e.sc));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    // rst  mr  wr    rs    rt   br mq ma sy rs | en        fl      st wc sc ht to
    tbl.push_back(v(1,0,5'd0,5'd0,5'd0,0,0,0,0,0, 5'b00000,3'b111,0,0,0, 0,0)); // in reset
    tbl.push_back(v(0,0,5'd0,5'd0,5'd0,0,0,0,0,0, 5'b11111,3'b000,0,0,0, 0,0)); // idle
    tbl.push_back(v(0,1,5'd8,5'd8,5'd0,0,0,0,0,0, 5'b00111,3'b010,0,0,0, 0,0)); // load-use rs
    tbl.push_back(v(0,0,5'd0,5'd0,5'd0,0,0,0,0,0, 5'b11111,3'b000,0,0,1, 0,0));
    tbl.push_back(v(0,1,5'd5,5'd1,5'd5,0,0,0,0,0, 5'b00111,3'b010,0,0,1, 0,0)); // load-use rt
    tbl.push_back(v(0,1,5'd5,5'd1,5'd2,0,0,0,0,0, 5'b11111,3'b000,0,0,2, 0,0)); // no match
    tbl.push_back(v(0,0,5'd8,5'd8,5'd0,0,0,0,0,0, 5'b11111,3'b000,0,0,2, 0,0)); // not a load
    tbl.push_back(v(0,1,5'd0,5'd0,5'd0,0,0,0,0,0, 5'b11111,3'b000,0,0,2, 0,0)); // r0 dest
    tbl.push_back(v(0,1,5'd8,5'd8,5'd0,1,0,0,0,0, 5'b11111,3'b110,0,0,2, 0,0)); // hazard+branch
    tbl.push_back(v(0,0,5'd0,5'd0,5'd0,1,0,0,0,0, 5'b11111,3'b110,0,0,2, 0,0)); // branch
    tbl.push_back(v(0,0,5'd0,5'd0,5'd0,0,1,1,0,0, 5'b11111,3'b000,0,0,2, 0,0)); // req+ack
    tbl.push_back(v(0,0,5'd0,5'd0,5'd0,0,1,0,0,0, 5'b00001,3'b001,0,0,2, 0,0)); // wait entry
    tbl.push_back(v(0,0,5'd0,5'd0,5'd0,0,1,0,0,0, 5'b00001,3'b001,1,1,3, 0,0));
    tbl.push_back(v(0,0,5'd0,5'd0,5'd0,1,1,0,0,0, 5'b00001,3'b001,1,2,4, 0,0)); // wait beats branch
    tbl.push_back(v(0,0,5'd0,5'd0,5'd0,0,1,1,0,0, 5'b11111,3'b000,1,3,5, 0,0)); // ack
    tbl.push_back(v(0,0,5'd0,5'd0,5'd0,0,0,0,0,0, 5'b11111,3'b000,0,0,5, 0,0));
    tbl.push_back(v(0,0,5'd0,5'd0,5'd0,0,1,0,0,0, 5'b00001,3'b001,0,0,5, 0,0));
    tbl.push_back(v(0,1,5'd3,5'd3,5'd0,0,1,1,0,0, 5'b00111,3'b010,1,1,6, 0,0)); // ack + load-use
    tbl.push_back(v(0,0,5'd0,5'd0,5'd0,0,0,0,0,0, 5'b11111,3'b000,0,0,7, 0,0));
    tbl.push_back(v(0,0,5'd0,5'd0,5'd0,1,1,0,1,0, 5'b00000,3'b001,0,0,7, 0,0)); // syscall wins
    tbl.push_back(v(0,1,5'd3,5'd3,5'd0,0,1,0,0,0, 5'b00000,3'b000,2,0,8, 1,0)); // HALT
    tbl.push_back(v(0,0,5'd0,5'd0,5'd0,0,0,0,0,1, 5'b00000,3'b000,2,0,8, 1,0)); // resume
    tbl.push_back(v(0,0,5'd0,5'd0,5'd0,0,0,0,0,0, 5'b11111,3'b000,0,0,8, 0,0));

    @(posedge clk);
    #1;
    n = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      applyCycle(tbl[i], n);
      n++;
    end

    // Timeout after four unacknowledged MEMWAIT cycles; resume ignored; reset clears.
    applyCycle(v(0,0,5'd0,5'd0,5'd0,0,1,0,0,0, 5'b00001,3'b001,0,0,8,  0,0), n++);
    applyCycle(v(0,0,5'd0,5'd0,5'd0,0,1,0,0,0, 5'b00001,3'b001,1,1,9,  0,0), n++);
    applyCycle(v(0,0,5'd0,5'd0,5'd0,0,1,0,0,0, 5'b00001,3'b001,1,2,10, 0,0), n++);
    applyCycle(v(0,0,5'd0,5'd0,5'd0,0,1,0,0,0, 5'b00001,3'b001,1,3,11, 0,0), n++);
    applyCycle(v(0,0,5'd0,5'd0,5'd0,0,1,0,0,0, 5'b00001,3'b001,1,4,12, 0,0), n++);
    applyCycle(v(0,0,5'd0,5'd0,5'd0,0,0,0,0,1, 5'b00000,3'b000,2,0,13, 1,1), n++);
    applyCycle(v(0,0,5'd0,5'd0,5'd0,0,0,0,0,1, 5'b00000,3'b000,2,0,13, 1,1), n++);
    applyCycle(v(1,0,5'd0,5'd0,5'd0,0,0,0,0,0, 5'b00000,3'b111,2,0,13, 1,1), n++);
    applyCycle(v(0,0,5'd0,5'd0,5'd0,0,0,0,0,0, 5'b11111,3'b000,0,0,0,  0,0), n++);

    // Ack on the timeout cycle takes precedence.
    applyCycle(v(0,0,5'd0,5'd0,5'd0,0,1,0,0,0, 5'b00001,3'b001,0,0,0, 0,0), n++);
    applyCycle(v(0,0,5'd0,5'd0,5'd0,0,1,0,0,0, 5'b00001,3'b001,1,1,1, 0,0), n++);
    applyCycle(v(0,0,5'd0,5'd0,5'd0,0,1,0,0,0, 5'b00001,3'b001,1,2,2, 0,0), n++);
    applyCycle(v(0,0,5'd0,5'd0,5'd0,0,1,0,0,0, 5'b00001,3'b001,1,3,3, 0,0), n++);
    applyCycle(v(0,0,5'd0,5'd0,5'd0,0,1,1,0,0, 5'b11111,3'b000,1,4,4, 0,0), n++);
    applyCycle(v(0,0,5'd0,5'd0,5'd0,0,0,0,0,0, 5'b11111,3'b000,0,0,4, 0,0), n++);

    // Reset in the middle of MEMWAIT.
    applyCycle(v(0,0,5'd0,5'd0,5'd0,0,1,0,0,0, 5'b00001,3'b001,0,0,4, 0,0), n++);
    applyCycle(v(0,0,5'd0,5'd0,5'd0,0,1,0,0,0, 5'b00001,3'b001,1,1,5, 0,0), n++);
    applyCycle(v(1,0,5'd0,5'd0,5'd0,0,1,0,0,0, 5'b00000,3'b111,1,2,6, 0,0), n++);
    applyCycle(v(0,0,5'd0,5'd0,5'd0,0,0,0,0,0, 5'b11111,3'b000,0,0,0, 0,0), n++);

    // Syscall while waiting on memory.
    applyCycle(v(0,0,5'd0,5'd0,5'd0,0,1,0,0,0, 5'b00001,3'b001,0,0,0, 0,0), n++);
    applyCycle(v(0,0,5'd0,5'd0,5'd0,0,1,0,1,0, 5'b00000,3'b001,1,1,1, 0,0), n++);
    applyCycle(v(0,0,5'd0,5'd0,5'd0,0,0,0,0,1, 5'b00000,3'b000,2,0,2, 1,0), n++);
    applyCycle(v(0,0,5'd0,5'd0,5'd0,0,0,0,0,0, 5'b11111,3'b000,0,0,2, 0,0), n++);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL be the number of MEMWAIT cycles without memAck_i before timeout (1..255).
REQ-002 Parameter CNT_W, default 16, SHALL be the width of the stall-cycle counter.
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-005 memtoReg1_i  in  1  SHALL indicate that the ID/EX instruction is a load.
REQ-006 writeReg1_i  in  5  SHALL be the ID/EX destination register.
REQ-007 rs_i, rt_i  in  5 each  SHALL be the IF/ID source registers.
REQ-008 branchTaken_i  in  1  SHALL indicate a taken branch or jump resolved in EX.
REQ-009 memReq_i  in  1  SHALL indicate a data-memory access in the MEM stage.
REQ-010 memAck_i  in  1  SHALL indicate that data memory completes the access this cycle.
REQ-011 syscallFlag3_i  in  1  SHALL indicate a syscall in the MEM/WB output.
REQ-012 resume_i  in  1  SHALL request exit from HALT.
REQ-013 pcEn_o, ifidEn_o, idexEn_o, exmemEn_o, memwbEn_o  out  1 each  SHALL be the stage-register load enables.
REQ-014 ifidFlush_o, idexFlush_o, memwbFlush_o  out  1 each  SHALL load a bubble (all controls 0) into that register.
REQ-015 state_o  out  2  SHALL report the state: RUN=0, MEMWAIT=1, HALT=2.
REQ-016 halted_o  out  1  SHALL be high while in HALT.
REQ-017 memTimeout_o  out  1  SHALL be a sticky memory-timeout flag.
REQ-018 waitCnt_o  out  8  SHALL report the current MEMWAIT cycle count.
REQ-019 stallCnt_o  out  CNT_W  SHALL count cycles with pcEn_o=0 outside HALT, saturating at all-ones.

Function
REQ-020 State, counters and flags SHALL be registered; enables and flushes SHALL be combinational from state and inputs, with zero-cycle latency.
REQ-021 The default in RUN with no event SHALL be all enables 1 and all flushes 0.
REQ-022 Event priority in RUN and MEMWAIT SHALL be: syscall > memory wait > branch > load-use.
REQ-023 Syscall (RUN, syscallFlag3_i=1): all enables SHALL be 0 and memwbFlush_o SHALL be 1; the next state SHALL be HALT.
REQ-024 Memory wait entry (RUN, memReq_i=1, memAck_i=0): pcEn, ifidEn, idexEn and exmemEn SHALL be 0 and memwbFlush_o SHALL be 1; the next state SHALL be MEMWAIT and waitCnt SHALL be 1.
REQ-025 memReq_i with memAck_i in the same cycle SHALL cause no stall.
REQ-026 MEMWAIT without ack: outputs SHALL freeze as in REQ-024 and waitCnt SHALL increment.
REQ-027 MEMWAIT with ack: the cycle SHALL be evaluated as a RUN cycle (branch and load-use apply), the next state SHALL be RUN and waitCnt SHALL be 0.
REQ-028 Timeout: in MEMWAIT with waitCnt==TIMEOUT and memAck_i=0, memTimeout_o SHALL be set and the next state SHALL be HALT; ack in that same cycle SHALL take precedence (no timeout).
REQ-029 Branch (branchTaken_i=1, no higher event): pcEn SHALL be 1, and ifidFlush_o and idexFlush_o SHALL be 1.
REQ-030 Load-use hazard: defined as memtoReg1_i=1, writeReg1_i!=0, and writeReg1_i==rs_i or writeReg1_i==rt_i.
REQ-031 On a load-use hazard with no higher event: pcEn and ifidEn SHALL be 0, idexFlush_o SHALL be 1, and the remaining enables SHALL be 1.
REQ-032 A hazard coincident with a branch SHALL be ignored, because the dependent instruction is squashed.
REQ-033 HALT: all enables SHALL be 0, all flushes 0 and halted_o 1; resume_i=1 with memTimeout_o=0 SHALL return to RUN next cycle.
REQ-034 resume_i SHALL be ignored while memTimeout_o=1.
REQ-035 stallCnt_o SHALL increment each non-HALT cycle with pcEn_o=0 and SHALL hold at the maximum value.

Reset
REQ-036 While rst=1: all enables SHALL be 0 and all flushes 1.
REQ-037 The next state after reset SHALL be RUN, with halted_o=0, memTimeout_o=0, waitCnt_o=0 and stallCnt_o=0.
REQ-038 Reset SHALL override any state, including mid-MEMWAIT and HALT.

Verification
REQ-039 Load-use: memtoReg1_i=1, writeReg1_i=8, rs_i=8 in RUN -> pcEn=0, ifidEn=0, idexFlush=1 for 1 cycle; stallCnt_o=1.
REQ-040 Hazard with writeReg1_i=0 (rs_i=0) -> no stall; same hazard with branchTaken_i=1 -> pcEn=1, ifidFlush=1, idexFlush=1.
REQ-041 memReq_i=1 and ack after 3 cycles -> state_o 1 for 3 cycles, waitCnt 1,2,3, RUN after the ack cycle, stallCnt_o=3.
REQ-042 TIMEOUT=4 with no ack -> HALT after the 4th MEMWAIT cycle, memTimeout_o=1; resume_i ignored; rst clears it.
REQ-043 syscallFlag3_i=1 coincident with memReq_i=1 and branchTaken_i=1 -> all enables 0, memwbFlush=1, HALT next cycle; resume_i -> RUN next cycle.
REQ-044 rst asserted in MEMWAIT with waitCnt_o=2 -> next cycle state_o=0 and all counters and flags 0.
